uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Parametrised, runtime-configurable UART transmitter. Successor to the fixed 8N1 transmitter in the serial debug path of the SDRAM/VGA design.
- Adds:
  - an internal baud-tick generator;
  - a DBIT parameter;
  - runtime parity (none/even/odd) and stop-bit (1/1.5/2) selection;
  - a one-entry holding buffer with a valid/ready handshake, so frames can be sent back to back.
- Drives the board TX pin directly.

Parameters:
- DBIT, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, baud ticks per bit; must be even and ≥4.
- DIV_W, 16, width of the runtime baud divisor.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- divisor  in  DIV_W  clk cycles per baud tick; 0 is treated as 1
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- stop_mode  in  2  00 one, 01 one-and-half, 10 two, 11 treated as one
- tx_data  in  DBIT  byte to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  holding buffer empty
- tx_busy  out  1  FSM not in IDLE
- tx_done_tick  out  1  one-cycle pulse per completed frame
- data_out  out  1  serial line, idle high

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM goes to IDLE; buffer, divider and counters clear.
  - Outputs: data_out=1, tx_ready=1, tx_busy=0, tx_done_tick=0.
  - Reset mid-frame aborts the frame: line returns high immediately and buffered data is discarded.
- Handshake:
  - A transfer occurs on the rising edge where tx_valid && tx_ready. tx_data is copied into the holding register and tx_ready drops the next cycle.
  - tx_ready=1 whenever the holding register is empty.
  - tx_valid held while tx_ready=0 is ignored.
  - A transfer in the same cycle that the FSM pops the buffer is accepted; the buffer stays full.
- Frame start:
  - FSM pops the holding register into its shift register in IDLE, or on the final stop tick when the buffer is full.
  - parity_mode and stop_mode are latched at the pop. Changing them mid-frame has no effect.
  - divisor is not latched; it is sampled live by the divider.
- Baud divider:
  - Held at 0 in IDLE; starts counting at entry to START.
  - Pulses tick when count == max(divisor,1)-1, then wraps to 0.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE, or STOP → START when the buffer is full.
  - START: line 0 for OVERSAMPLE ticks (full bit, unlike the old half bit).
  - DATA: LSB first, each bit OVERSAMPLE ticks, DBIT bits. Bit counter is $clog2(DBIT) bits wide, and so is 4 bits wide when DBIT=9.
  - PARITY: entered only if latched mode is even/odd. Line carries ^data (even) or ~^data (odd) for OVERSAMPLE ticks.
  - STOP: line 1 for OVERSAMPLE, 3*OVERSAMPLE/2, or 2*OVERSAMPLE ticks per stop_mode.
  - Tick counter is $clog2(2*OVERSAMPLE) bits and resets to 0 at every bit boundary.
- Back to back:
  - On the final stop tick with the buffer full, the FSM goes straight to START. No extra idle cycle is inserted between the stop bit and the next start bit.
- Outputs:
  - data_out is registered.
  - Latency from the accepting edge in IDLE to data_out falling: 2 clk edges.
  - tx_done_tick is registered: high for exactly one cycle after the edge on which the final stop tick is consumed, including on back-to-back frames.
  - tx_busy = (state != IDLE).
- Timing invariant: frame length in ticks = OVERSAMPLE*(1+DBIT+P) + stop ticks, where P=1 if parity is enabled, else 0.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity_mode codes PAR_NONE/EVEN/ODD;
  - stop_mode codes STOP_1/STOP_1P5/STOP_2;
  - a function returning stop ticks for (stop_mode, OVERSAMPLE).
- One sub-module, uart_baud_gen:
  - inputs clk, reset_n, enable, divisor; output tick;
  - also reusable by a future uart_rx successor.

Test Plan:
- Divisor 1, OVERSAMPLE=16, DBIT=8, none/1 stop, send 0x55:
  - data_out sequence 0,1,0,1,0,1,0,1,0,1 (LSB first), each level 16 cycles;
  - frame 160 cycles; tx_done_tick one pulse; tx_busy falls.
- Parity, send 0x07:
  - even mode → parity bit 1;
  - odd mode → parity bit 0;
  - frame is 176 cycles in both modes.
- stop_mode=01, divisor=3, send 0xFF → stop high for 24 ticks = 72 cycles. Then change stop_mode mid-frame and confirm no effect on the current frame.
- Push 0xA5 then 0x3C with tx_valid held high:
  - second accepted while the first transmits; tx_ready low until the pop;
  - 0x3C start bit follows the last 0xA5 stop tick with no extra idle cycle;
  - two done pulses.
- Assert reset_n low at the 5th data bit:
  - data_out=1, tx_ready=1, tx_busy=0 asynchronously;
  - after release, the line stays idle with no residual frame.
- divisor=0 behaves identically to divisor=1. DBIT=9, send 0x1AB → 9 data bits, frame 176 cycles at divisor 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, mode codes and stop-length helper for the UART blocks
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [1:0] PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10;
    localparam logic [1:0] STOP_1 = 2'b00, STOP_1P5 = 2'b01, STOP_2 = 2'b10;
    // stop length in baud ticks; the unused code falls back to one stop bit
    function automatic int stop_ticks(input logic [1:0] mode, input int os);
        return mode == STOP_1 ? os : mode == STOP_1P5 ? 3 * os / 2 : mode == STOP_2 ? 2 * os : os;
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: runtime-divisor baud tick generator, idle at zero while disabled
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);
    logic [DIV_W-1:0] count, last;
    assign last = divisor == '0 ? '0 : divisor - DIV_W'(1);
    assign tick = enable && count >= last;
    // count while enabled, wrapping on each tick; divisor is followed live
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) count <= '0;
        else count <= (!enable || tick) ? '0 : count + DIV_W'(1);
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with one-entry holding buffer
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       parity_mode,
    input  logic [1:0]       stop_mode,
    input  logic [DBIT-1:0]  tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_done_tick,
    output logic             data_out
);
    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam int BW = $clog2(DBIT);
    state_t state, nxt;
    logic [TW-1:0] tcnt, tcnt_n, last;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [DBIT-1:0] hold, sh, sh_n;
    logic [1:0] stop_l;
    logic full, accept, pop, tick, bit_end, par_en, par_bit, line_n, done_n;
    assign tx_ready = !full;
    assign tx_busy  = state != IDLE;
    assign accept   = tx_valid && !full;
    assign last     = TW'((state == STOP ? stop_ticks(stop_l, OVERSAMPLE) : OVERSAMPLE) - 1);
    assign bit_end  = tick && tcnt == last;
    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk(clk), .reset_n(reset_n), .enable(tx_busy), .divisor(divisor), .tick(tick)
    );
    // next state, counters, and the level the line takes in the next state
    always_comb begin
        nxt    = state;
        tcnt_n = tick ? (bit_end ? '0 : tcnt + TW'(1)) : tcnt;
        bcnt_n = bcnt;
        pop    = 1'b0;
        done_n = 1'b0;
        unique case (state)
            IDLE:   if (full) begin pop = 1'b1; nxt = START; end
            START:  if (bit_end) begin nxt = DATA; bcnt_n = '0; end
            DATA:   if (bit_end) begin
                        bcnt_n = bcnt + BW'(1);
                        if (bcnt == BW'(DBIT - 1)) nxt = par_en ? PARITY : STOP;
                    end
            PARITY: if (bit_end) nxt = STOP;
            STOP:   if (bit_end) begin done_n = 1'b1; pop = full; nxt = full ? START : IDLE; end
            default: nxt = IDLE;
        endcase
        sh_n   = pop ? hold : (state == DATA && bit_end) ? sh >> 1 : sh;
        line_n = nxt == START ? 1'b0 : nxt == DATA ? sh_n[0] : nxt == PARITY ? par_bit : 1'b1;
    end
    // FSM registers, registered outputs and per-frame configuration latched at pop
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state        <= IDLE;
            tcnt         <= '0;
            bcnt         <= '0;
            sh           <= '0;
            par_en       <= 1'b0;
            par_bit      <= 1'b0;
            stop_l       <= STOP_1;
            data_out     <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= nxt;
            tcnt         <= tcnt_n;
            bcnt         <= bcnt_n;
            sh           <= sh_n;
            data_out     <= line_n;
            tx_done_tick <= done_n;
            if (pop) begin
                par_en  <= parity_mode != PAR_NONE && parity_mode != 2'b11;
                par_bit <= (parity_mode == PAR_ODD) ^ (^hold);
                stop_l  <= stop_mode;
            end
        end
    // one-entry holding buffer in front of the shift register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            full <= 1'b0;
            hold <= '0;
        end else begin
            full <= accept | (full & !pop);
            if (accept) hold <= tx_data;
        end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboarded directed and random bench for uart_tx_cfg (DBIT 8 and 9)
`timescale 1ns/1ps
module tb_uart_tx_cfg;
    localparam int OS = 16;
    logic clk = 0, reset_n = 1, sel = 0;
    logic [15:0] divisor = 16'd1;
    logic [1:0] parity_mode = 0, stop_mode = 0;
    logic [7:0] data8 = 0;
    logic [8:0] data9 = 0;
    logic valid8 = 0, valid9 = 0;
    logic ready8, ready9, busy8, busy9, done8, done9, line8, line9, line, dsel;
    int checks = 0, errors = 0, done_cnt = 0, b2b_cnt = 0;
    typedef struct { logic [11:0] seq; int nb; int per; int n; } frame_t;
    frame_t exp_q[$];

    always #5 clk = ~clk;
    assign line = sel ? line9 : line8;
    assign dsel = sel ? done9 : done8;

    uart_tx_cfg #(.DBIT(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .divisor(divisor), .parity_mode(parity_mode),
        .stop_mode(stop_mode), .tx_data(data8), .tx_valid(valid8), .tx_ready(ready8),
        .tx_busy(busy8), .tx_done_tick(done8), .data_out(line8));
    uart_tx_cfg #(.DBIT(9)) dut9 (
        .clk(clk), .reset_n(reset_n), .divisor(divisor), .parity_mode(parity_mode),
        .stop_mode(stop_mode), .tx_data(data9), .tx_valid(valid9), .tx_ready(ready9),
        .tx_busy(busy9), .tx_done_tick(done9), .data_out(line9));

    // reference frame: bit levels in order, bit period and total length in clk cycles
    function automatic frame_t model(input logic [8:0] d, input int dbit, input logic [1:0] pm,
                                     input logic [1:0] sm, input logic [15:0] div);
        frame_t f;
        int ones = 0, p, st, dv;
        dv = div == 0 ? 1 : int'(div);
        p  = (pm == 2'd1 || pm == 2'd2) ? 1 : 0;
        st = sm == 2'd1 ? OS * 3 / 2 : sm == 2'd2 ? OS * 2 : OS;
        f.seq = '1;
        f.seq[0] = 1'b0;
        for (int i = 0; i < dbit; i++) begin
            f.seq[1 + i] = d[i];
            ones += int'(d[i]);
        end
        if (p == 1) f.seq[1 + dbit] = (pm == 2'd1) ? ones[0] : !ones[0];
        f.nb  = 1 + dbit + p;
        f.per = OS * dv;
        f.n   = f.per * f.nb + st * dv;
        return f;
    endfunction

    function automatic logic lvl(input frame_t f, input int k);
        int b = k / f.per;
        return b < f.nb ? f.seq[b] : 1'b1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // monitor: each start bit pops one expected frame and compares it cycle by cycle
    initial begin : monitor
        frame_t f;
        bit have = 0;
        int bad, first;
        forever begin
            if (!have) @(negedge clk);
            have = 0;
            if (!reset_n || line) continue;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: start bit at %0t with empty scoreboard", $time);
                for (int i = 0; i < 20000 && line == 1'b0; i++) @(negedge clk);
                continue;
            end
            f = exp_q.pop_front();
            bad = 0;
            first = -1;
            for (int k = 0; k < f.n; k++) begin
                if (k > 0) @(negedge clk);
                if (!reset_n) break;
                if (line !== lvl(f, k) || (k > 0 && dsel)) begin
                    bad++;
                    if (first < 0) first = k;
                end
            end
            if (!reset_n) continue;
            if (bad != 0) begin
                errors++;
                $display("FAIL frame_wave: %0d bad cycles, first at cycle %0d (line=%b expected %b) of %0d",
                         bad, first, line, lvl(f, first), f.n);
            end
            @(negedge clk);
            check("done_after_frame", int'(dsel), 1);
            if (reset_n && !line) b2b_cnt++;
            have = 1;
        end
    end

    always @(negedge clk) if (reset_n && dsel) done_cnt++;

    task automatic send(input logic [8:0] d, input logic [1:0] pm, input logic [1:0] sm);
        int w = 0;
        while (!(sel ? ready9 : ready8) && w < 20000) begin @(posedge clk); #1; w++; end
        if (w >= 20000) begin check("ready_timeout", 0, 1); return; end
        parity_mode = pm;
        stop_mode = sm;
        if (sel) begin data9 = d; valid9 = 1; end
        else begin data8 = d[7:0]; valid8 = 1; end
        exp_q.push_back(model(d, sel ? 9 : 8, pm, sm, divisor));
        @(posedge clk); #1;
        valid8 = 0;
        valid9 = 0;
    endtask

    task automatic frame_len(input int chg_at, input logic [1:0] chg_sm, output int n);
        int w = 0;
        n = 0;
        while (!(sel ? busy9 : busy8) && w < 20) begin @(posedge clk); #1; w++; end
        while ((sel ? busy9 : busy8) && n < 20000) begin
            @(posedge clk); #1;
            n++;
            if (n == chg_at) stop_mode = chg_sm;
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || busy8 || busy9) && w < 30000) begin @(posedge clk); #1; w++; end
        if (w >= 30000) check("drain_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, d0, b0, w;
        #2 reset_n = 0;
        #1;
        check("rst_data_out", int'(line8), 1);
        check("rst_ready", int'(ready8), 1);
        check("rst_busy", int'(busy8), 0);
        check("rst_done", int'(done8), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk); #1;
        d0 = done_cnt;
        send(9'h055, 2'd0, 2'd0);
        frame_len(0, 2'd0, n);
        check("len_8n1", n, 160);
        drain();
        check("done_pulses_8n1", done_cnt - d0, 1);
        send(9'h007, 2'd1, 2'd0);
        frame_len(0, 2'd0, n);
        check("len_even", n, 176);
        send(9'h007, 2'd2, 2'd0);
        frame_len(0, 2'd0, n);
        check("len_odd", n, 176);
        drain();
        divisor = 3;
        send(9'h0FF, 2'd0, 2'd1);
        frame_len(100, 2'd2, n);
        check("len_stop1p5_div3", n, 504);
        drain();
        divisor = 1;
        d0 = done_cnt;
        b0 = b2b_cnt;
        parity_mode = 0;
        stop_mode = 0;
        data8 = 8'hA5;
        valid8 = 1;
        exp_q.push_back(model(9'h0A5, 8, 2'd0, 2'd0, divisor));
        @(posedge clk); #1;
        data8 = 8'h3C;
        exp_q.push_back(model(9'h03C, 8, 2'd0, 2'd0, divisor));
        w = 0;
        while (!ready8 && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        valid8 = 0;
        check("b2b_ready_after_accept", int'(ready8), 0);
        repeat (100) @(posedge clk);
        #1 check("b2b_ready_held_low", int'(ready8), 0);
        repeat (58) @(posedge clk);
        #1 check("b2b_ready_before_pop", int'(ready8), 0);
        @(posedge clk);
        #1 check("b2b_ready_after_pop", int'(ready8), 1);
        drain();
        check("b2b_done_pulses", done_cnt - d0, 2);
        check("b2b_no_gap", b2b_cnt - b0, 1);
        d0 = done_cnt;
        send(9'h00F, 2'd0, 2'd0);
        send(9'h033, 2'd0, 2'd0);
        repeat (85) @(posedge clk);
        #3 check("abort_line_low", int'(line8), 0);
        reset_n = 0;
        #1;
        check("abort_data_out", int'(line8), 1);
        check("abort_ready", int'(ready8), 1);
        check("abort_busy", int'(busy8), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        repeat (400) @(posedge clk);
        #1;
        check("post_abort_line", int'(line8), 1);
        check("post_abort_busy", int'(busy8), 0);
        check("post_abort_done", done_cnt - d0, 0);
        divisor = 0;
        send(9'h055, 2'd0, 2'd0);
        frame_len(0, 2'd0, n);
        check("len_div0", n, 160);
        drain();
        sel = 1;
        divisor = 1;
        send(9'h1AB, 2'd0, 2'd0);
        frame_len(0, 2'd0, n);
        check("len_dbit9", n, 176);
        drain();
        for (int i = 0; i < 6; i++) send(9'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        drain();
        sel = 0;
        for (int b = 0; b < 4; b++) begin
            divisor = 16'(b);
            for (int i = 0; i < 8; i++) begin
                send(9'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 300)) @(posedge clk);
                    #1;
                end
            end
            drain();
        end
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
